hazard_stall_controller: RTL and testbench

- Pipeline sequencing controller for the 5-stage datapath; companion to the EX-stage forwarding logic.
- Handles the three cases forwarding cannot cover: load-use stalls, taken-branch flushes, and freezing the pipe while the multi-cycle mul/div unit runs.
- Drives the PC, IF/ID and ID/EX write enables, bubble/flush controls and the mul/div start handshake. Keeps a saturating stall-cycle counter.

---
 rtl/hazard_stall_controller.sv | 152 +++++++++++++++
 tb/tb_hazard_stall_controller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
//   Pipeline sequencing controller for the 5-stage datapath. It covers the
//   hazards the EX forwarding network cannot resolve on its own:
//   load-use stalls, taken-branch flushes, and freezing the pipe while the
//   multi-cycle mul/div unit is busy. It also keeps a saturating count of
//   the cycles in which the PC was held.
//
// Ports
//   Clk, Rst_n               clock, asynchronous active-low reset
//   IDrs, IDrt               source register fields of the ID instruction
//   IDUsesRs, IDUsesRt       ID instruction actually reads rs / rt
//   EXrt, EXMemRead          destination register and load flag of EX instr
//   EXMulDiv                 EX instruction is a mul/div
//   BranchTaken              branch in EX resolved taken
//   MulDivDone               mul/div result valid (single-cycle pulse)
//   PCWrite, IFIDWrite,
//   IDEXWrite                pipeline register write enables
//   IDEXBubble, EXMEMBubble  zero the control bits written into ID/EX, EX/MEM
//   IFIDFlush, IDEXFlush     clear IF/ID, ID/EX to NOP
//   MulDivStart              single-cycle start pulse to the mul/div unit
//   MDTimeout                sticky: some mul/div wait was force-released
//   StallCycles              saturating count of cycles with PCWrite=0

module hazard_stall_controller #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [4:0]       IDrs,
    input  logic [4:0]       IDrt,
    input  logic             IDUsesRs,
    input  logic             IDUsesRt,
    input  logic [4:0]       EXrt,
    input  logic             EXMemRead,
    input  logic             EXMulDiv,
    input  logic             BranchTaken,
    input  logic             MulDivDone,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXWrite,
    output logic             IDEXBubble,
    output logic             EXMEMBubble,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             MulDivStart,
    output logic             MDTimeout,
    output logic [CNT_W-1:0] StallCycles
);

    localparam int WW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(MD_TIMEOUT - 1);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [WW-1:0]   wait_cnt;
    logic            cnt_clr, cnt_inc, to_set;
    logic            load_use;

    // r0 is hardwired zero, so a load targeting it can never create a hazard.
    assign load_use = EXMemRead && (EXrt != 5'd0) &&
                      ((IDUsesRs && (EXrt == IDrs)) ||
                       (IDUsesRt && (EXrt == IDrt)));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (cnt_clr)
                wait_cnt <= '0;
            else if (cnt_inc)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        to_set      = 1'b0;
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IDEXWrite   = 1'b1;
        IDEXBubble  = 1'b0;
        EXMEMBubble = 1'b0;
        IFIDFlush   = 1'b0;
        IDEXFlush   = 1'b0;
        MulDivStart = 1'b0;
        // Outputs are combinational, so hold them at the idle values while
        // reset is asserted; otherwise a held EXMulDiv would fire a start.
        if (Rst_n) begin
            unique case (state)
                RUN: begin
                    if (EXMulDiv) begin
                        MulDivStart = 1'b1;
                        PCWrite     = 1'b0;
                        IFIDWrite   = 1'b0;
                        IDEXWrite   = 1'b0;
                        EXMEMBubble = 1'b1;
                        cnt_clr     = 1'b1;
                        state_nxt   = MD_WAIT;
                    end else if (BranchTaken) begin
                        // ID holds a wrong-path instruction: any load-use
                        // match on it is meaningless, so it is not stalled.
                        IFIDFlush = 1'b1;
                        IDEXFlush = 1'b1;
                    end else if (load_use) begin
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        IDEXBubble = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (MulDivDone) begin
                        // Release in the Done cycle so the result is
                        // captured into EX/MEM; Done wins over timeout.
                        state_nxt = RUN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        to_set    = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        PCWrite     = 1'b0;
                        IFIDWrite   = 1'b0;
                        IDEXWrite   = 1'b0;
                        EXMEMBubble = 1'b1;
                        cnt_inc     = 1'b1;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            MDTimeout   <= 1'b0;
            StallCycles <= '0;
        end else begin
            if (to_set)
                MDTimeout <= 1'b1;
            if (!PCWrite && (StallCycles != {CNT_W{1'b1}}))
                StallCycles <= StallCycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller. Two instances share stimulus:
// dut_a uses the default parameters, dut_b uses MD_TIMEOUT=4, CNT_W=4 for
// the timeout and saturation cases. Control outputs are compared as one
// byte: {PCWrite,IFIDWrite,IDEXWrite,IDEXBubble,EXMEMBubble,IFIDFlush,
// IDEXFlush,MulDivStart}.

module tb_hazard_stall_controller;

    localparam logic [7:0] C_DEF   = 8'b1110_0000;
    localparam logic [7:0] C_LU    = 8'b0011_0000;
    localparam logic [7:0] C_BR    = 8'b1110_0110;
    localparam logic [7:0] C_START = 8'b0000_1001;
    localparam logic [7:0] C_FRZ   = 8'b0000_1000;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic [4:0] IDrs, IDrt, EXrt;
    logic       IDUsesRs, IDUsesRt, EXMemRead, EXMulDiv, BranchTaken, MulDivDone;

    logic        a_pcw, a_ifw, a_idw, a_idb, a_exb, a_iff, a_idf, a_mds, a_to;
    logic [15:0] a_cnt;
    logic        b_pcw, b_ifw, b_idw, b_idb, b_exb, b_iff, b_idf, b_mds, b_to;
    logic [3:0]  b_cnt;
    logic [7:0]  ctrl_a, ctrl_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    assign ctrl_a = {a_pcw, a_ifw, a_idw, a_idb, a_exb, a_iff, a_idf, a_mds};
    assign ctrl_b = {b_pcw, b_ifw, b_idw, b_idb, b_exb, b_iff, b_idf, b_mds};

    hazard_stall_controller dut_a (
        .Clk(Clk), .Rst_n(Rst_n), .IDrs(IDrs), .IDrt(IDrt),
        .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt), .EXrt(EXrt),
        .EXMemRead(EXMemRead), .EXMulDiv(EXMulDiv), .BranchTaken(BranchTaken),
        .MulDivDone(MulDivDone), .PCWrite(a_pcw), .IFIDWrite(a_ifw),
        .IDEXWrite(a_idw), .IDEXBubble(a_idb), .EXMEMBubble(a_exb),
        .IFIDFlush(a_iff), .IDEXFlush(a_idf), .MulDivStart(a_mds),
        .MDTimeout(a_to), .StallCycles(a_cnt)
    );

    hazard_stall_controller #(.MD_TIMEOUT(4), .CNT_W(4)) dut_b (
        .Clk(Clk), .Rst_n(Rst_n), .IDrs(IDrs), .IDrt(IDrt),
        .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt), .EXrt(EXrt),
        .EXMemRead(EXMemRead), .EXMulDiv(EXMulDiv), .BranchTaken(BranchTaken),
        .MulDivDone(MulDivDone), .PCWrite(b_pcw), .IFIDWrite(b_ifw),
        .IDEXWrite(b_idw), .IDEXBubble(b_idb), .EXMEMBubble(b_exb),
        .IFIDFlush(b_iff), .IDEXFlush(b_idf), .MulDivStart(b_mds),
        .MDTimeout(b_to), .StallCycles(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        IDrs = 5'd0; IDrt = 5'd0; EXrt = 5'd0;
        IDUsesRs = 1'b0; IDUsesRt = 1'b0; EXMemRead = 1'b0;
        EXMulDiv = 1'b0; BranchTaken = 1'b0; MulDivDone = 1'b0;
    endtask

    // short reset pulse placed mid-cycle, away from the rising edge
    task automatic do_reset();
        #1 Rst_n = 1'b0;
        #1 Rst_n = 1'b1;
    endtask

    initial begin
        idle();
        Rst_n = 1'b0;
        #3;
        chk("rst_ctrl", ctrl_a, C_DEF);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_to", a_to, 0);
        tick();
        Rst_n = 1'b1;

        // load-use on rs: one stall cycle
        EXMemRead = 1'b1; EXrt = 5'd5; IDrs = 5'd5; IDUsesRs = 1'b1;
        #1 chk("lu_rs_ctrl", ctrl_a, C_LU);
        tick();
        idle();
        #1 chk("lu_rs_after", ctrl_a, C_DEF);
        chk("lu_rs_cnt", a_cnt, 1);

        // load-use on rt
        EXMemRead = 1'b1; EXrt = 5'd7; IDrt = 5'd7; IDUsesRt = 1'b1; IDrs = 5'd5;
        #1 chk("lu_rt_ctrl", ctrl_a, C_LU);
        tick();
        idle();

        // load to r0: no stall
        EXMemRead = 1'b1; EXrt = 5'd0; IDrs = 5'd0; IDUsesRs = 1'b1;
        #1 chk("lu_r0_ctrl", ctrl_a, C_DEF);
        tick();
        // match but source not used: no stall
        EXrt = 5'd9; IDrs = 5'd9; IDUsesRs = 1'b0; IDUsesRt = 1'b1; IDrt = 5'd3;
        #1 chk("lu_unused_ctrl", ctrl_a, C_DEF);
        tick();
        idle();
        #1 chk("lu_cnt2", a_cnt, 2);

        // branch beats load-use
        BranchTaken = 1'b1; EXMemRead = 1'b1; EXrt = 5'd4; IDrs = 5'd4; IDUsesRs = 1'b1;
        #1 chk("br_ctrl", ctrl_a, C_BR);
        tick();
        idle();
        #1 chk("br_cnt", a_cnt, 2);

        // mul/div with Done on the 5th wait cycle (dut_a)
        do_reset();
        chk("md_rst_cnt", a_cnt, 0);
        EXMulDiv = 1'b1; BranchTaken = 1'b1; EXMemRead = 1'b1; EXrt = 5'd2;
        IDrs = 5'd2; IDUsesRs = 1'b1;
        #1 chk("md_start", ctrl_a, C_START);
        tick();
        idle();
        for (int i = 1; i <= 4; i++) begin
            BranchTaken = 1'b1;
            #1 chk($sformatf("md_frz%0d", i), ctrl_a, C_FRZ);
            tick();
        end
        BranchTaken = 1'b0;
        MulDivDone = 1'b1;
        #1 chk("md_done_ctrl", ctrl_a, C_DEF);
        tick();
        MulDivDone = 1'b0;
        BranchTaken = 1'b1;  // flush only occurs in RUN
        #1 chk("md_back_run", ctrl_a, C_BR);
        chk("md_cnt", a_cnt, 5);
        chk("md_no_to", a_to, 0);
        tick();
        idle();

        // Done and timeout coincide (dut_b): Done wins, no flag
        do_reset();
        EXMulDiv = 1'b1;
        #1 chk("dt_start", ctrl_b, C_START);
        tick();
        EXMulDiv = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            #1 chk($sformatf("dt_frz%0d", i), ctrl_b, C_FRZ);
            tick();
        end
        MulDivDone = 1'b1;
        #1 chk("dt_rel", ctrl_b, C_DEF);
        tick();
        MulDivDone = 1'b0;
        #1 chk("dt_no_to", b_to, 0);

        // timeout (dut_b): release on the 4th wait cycle
        do_reset();
        EXMulDiv = 1'b1;
        tick();
        EXMulDiv = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            #1 chk($sformatf("to_frz%0d", i), ctrl_b, C_FRZ);
            tick();
        end
        #1 chk("to_rel", ctrl_b, C_DEF);
        tick();
        chk("to_flag", b_to, 1);
        chk("to_cnt", b_cnt, 4);
        tick();
        tick();
        chk("to_sticky", b_to, 1);
        EXMulDiv = 1'b1;
        #1 chk("to_restart", ctrl_b, C_START);
        tick();
        EXMulDiv = 1'b0;

        // reset during the 2nd wait cycle (dut_a)
        do_reset();
        EXMulDiv = 1'b1;
        tick();
        EXMulDiv = 1'b0;
        tick();
        #1 chk("rw_frz", ctrl_a, C_FRZ);
        EXMulDiv = 1'b1;
        Rst_n = 1'b0;
        #1 chk("rw_ctrl", ctrl_a, C_DEF);
        chk("rw_cnt", a_cnt, 0);
        chk("rw_to", a_to, 0);
        EXMulDiv = 1'b0;
        #1 Rst_n = 1'b1;
        tick();
        #1 chk("rw_after", ctrl_a, C_DEF);
        chk("rw_cnt_after", a_cnt, 0);

        // saturation: 20 load-use stall cycles
        do_reset();
        EXMemRead = 1'b1; EXrt = 5'd11; IDrt = 5'd11; IDUsesRt = 1'b1;
        repeat (20) tick();
        idle();
        #1 chk("sat_b", b_cnt, 15);
        chk("sat_a", a_cnt, 20);
        tick();
        chk("sat_hold", b_cnt, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
